fifo_stream_rx: RTL and testbench

Receiving end of the `fifo_stream` conduit: captures 256-bit words written with `fifo_write`, and treats `fifo_send` as the packet-commit strobe. Once a packet is committed, it is serialized least-significant-slice first onto a narrow valid/ready stream with SOP/EOP framing. The block sits between the data-acquisition subsystem's stream output and the downstream packet consumer (formatter or link). Packets that overflow the buffer are dropped whole and never partially emitted.

---
 rtl/fifo_stream_rx.sv | 144 ++++++++++++++
 tb/tb_fifo_stream_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_rx.sv
// Receive side of the fifo_stream conduit: buffers 256-bit words, commits them as
// packets on fifo_send and serializes committed packets LSB-slice first onto a framed stream.
module fifo_stream_rx #(
  parameter int DATA_W   = 256,
  parameter int OUT_W    = 32,
  parameter int DEPTH    = 16,
  parameter int MAX_PKTS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           fifo_data,
  input  logic                        fifo_write,
  input  logic                        fifo_send,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [$clog2(MAX_PKTS):0]   pkt_count,
  output logic                        overflow
);
  localparam int BEATS = DATA_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(MAX_PKTS);
  localparam int CW    = PW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       desc_mem [MAX_PKTS];

  logic [AW:0]       wr_ptr, rd_ptr, commit_ptr, cur_len, words_left, pkt_len;
  logic [PW:0]       desc_wr, desc_rd;
  logic              drop, first;
  logic              full, wr_acc, wr_ovf, desc_full, desc_empty;
  logic              commit_drop, commit_ok, hs, last_beat, eop_hs;
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     beat;

  always_comb begin
    full        = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    wr_acc      = fifo_write && !full && !drop;
    wr_ovf      = fifo_write && full && !drop;
    pkt_len     = cur_len + (AW+1)'(wr_acc);
    // Descriptor occupancy includes the packet currently being emitted.
    desc_full   = pkt_count == CW'(MAX_PKTS);
    desc_empty  = desc_wr == desc_rd;
    commit_drop = fifo_send && (drop || wr_ovf || desc_full);
    commit_ok   = fifo_send && !commit_drop && (pkt_len != '0);
    last_beat   = beat == BW'(BEATS - 1);
    out_valid   = state == SHIFT;
    out_data    = shreg[OUT_W-1:0];
    out_sop     = out_valid && first && (beat == '0);
    out_eop     = out_valid && last_beat && (words_left == (AW+1)'(1));
    hs          = out_valid && out_ready;
    eop_hs      = hs && out_eop;
  end

  // Write side: packet assembly, commit and whole-packet drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      cur_len    <= '0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
      desc_wr    <= '0;
    end else if (commit_drop) begin
      wr_ptr   <= commit_ptr;
      cur_len  <= '0;
      drop     <= 1'b0;
      overflow <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (wr_ovf) drop <= 1'b1;
      if (commit_ok) begin
        commit_ptr <= wr_ptr + (AW+1)'(wr_acc);
        cur_len    <= '0;
        desc_wr    <= desc_wr + CW'(1);
      end else if (wr_acc) begin
        cur_len <= cur_len + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= fifo_data;
    if (commit_ok) desc_mem[desc_wr[PW-1:0]] <= pkt_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (commit_ok && !eop_hs) begin
      pkt_count <= pkt_count + CW'(1);
    end else if (eop_hs && !commit_ok) begin
      pkt_count <= pkt_count - CW'(1);
    end
  end

  // Read side: descriptor pop, word load, beat serialization
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      desc_rd    <= '0;
      shreg      <= '0;
      beat       <= '0;
      words_left <= '0;
      first      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!desc_empty) begin
            words_left <= desc_mem[desc_rd[PW-1:0]];
            desc_rd    <= desc_rd + CW'(1);
            first      <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          shreg <= mem[rd_ptr[AW-1:0]];
          beat  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (out_ready) begin
            shreg <= shreg >> OUT_W;
            beat  <= beat + BW'(1);
            first <= 1'b0;
            if (last_beat) begin
              rd_ptr     <= rd_ptr + (AW+1)'(1);
              words_left <= words_left - (AW+1)'(1);
              state      <= (words_left == (AW+1)'(1)) ? IDLE : LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_stream_rx.sv
// Scoreboard bench for fifo_stream_rx: stimulus queues expected beats, a negedge monitor checks them.
module tb_fifo_stream_rx;
  localparam int DATA_W = 256;
  localparam int OUT_W  = 32;
  localparam int BEATS  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_write, fifo_send;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid, out_ready, out_sop, out_eop;
  logic [2:0]        pkt_count;
  logic              overflow;

  fifo_stream_rx #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(16), .MAX_PKTS(4)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_send(fifo_send), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .pkt_count(pkt_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  int          exp_pkts = 0;
  int          sop_cnt = 0;
  int          eop_cnt = 0;
  int          hs_cnt = 0;
  int          ready_mode = 1;
  logic [31:0] first_sop_data = '0;
  logic [31:0] last_eop_data = '0;
  logic        hold_pend = 1'b0;
  logic [33:0] hold_v = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkword(input int base);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(base + i);
    return w;
  endfunction

  task automatic expect_word(input logic [DATA_W-1:0] w, input logic first_w, input logic last_w);
    beat_t b;
    for (int i = 0; i < BEATS; i++) begin
      b.data = w[32*i +: 32];
      b.sop  = first_w && (i == 0);
      b.eop  = last_w && (i == BEATS - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input logic wr, input logic snd);
    fifo_data  = w;
    fifo_write = wr;
    fifo_send  = snd;
    @(posedge clk);
    #1;
    fifo_write = 1'b0;
    fifo_send  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_idle"}, out_valid, 0);
  endtask

  // Ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && out_valid) check("hold_stable", {out_data, out_sop, out_eop}, hold_v);
        if (out_valid && out_ready) begin
          hs_cnt++;
          hold_pend = 1'b0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got %0h required no beat", out_data);
          end else begin
            e = sb.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_sop", out_sop, e.sop);
            check("beat_eop", out_eop, e.eop);
          end
          if (out_sop) begin
            sop_cnt++;
            first_sop_data = out_data;
          end
          if (out_eop) begin
            eop_cnt++;
            last_eop_data = out_data;
            check("pkt_count_at_eop", pkt_count, exp_pkts);
            exp_pkts--;
          end
        end else if (out_valid) begin
          hold_pend = 1'b1;
          hold_v    = {out_data, out_sop, out_eop};
        end else begin
          hold_pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w0, w1, w2;
    int sop0, eop0, hs0, n;
    reset = 1'b1;
    fifo_data = '0;
    fifo_write = 1'b0;
    fifo_send = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_data", out_data, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single 2-word packet, latency and framing
    w0 = mkword(0);
    w1 = mkword(32);
    expect_word(w0, 1, 0);
    expect_word(w1, 0, 1);
    exp_pkts = 1;
    send_word(w0, 1, 0);
    send_word(w1, 1, 0);
    send_word('0, 0, 1);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_valid_n1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_n2", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_n3", out_valid, 1);
    check("t1_first_sop", out_sop, 1);
    check("t1_first_data", out_data, 32'h03020100);
    drain("t1");
    check("t1_last_eop_data", last_eop_data, 32'h3F3E3D3C);
    check("t1_first_sop_data", first_sop_data, 32'h03020100);
    check("t1_pkt_count_end", pkt_count, 0);

    // Random backpressure
    ready_mode = 2;
    expect_word(w0, 1, 0);
    expect_word(w1, 0, 1);
    exp_pkts = 1;
    send_word(w0, 1, 0);
    send_word(w1, 1, 0);
    send_word('0, 0, 1);
    drain("t2");
    check("t2_pkt_count_end", pkt_count, 0);
    ready_mode = 1;

    // Write together with send, then an empty send
    w0 = mkword(64);
    w1 = mkword(96);
    w2 = mkword(128);
    expect_word(w0, 1, 0);
    expect_word(w1, 0, 0);
    expect_word(w2, 0, 1);
    exp_pkts = 1;
    send_word(w0, 1, 0);
    send_word(w1, 1, 0);
    send_word(w2, 1, 1);
    check("t3_pkt_count", pkt_count, 1);
    send_word('0, 0, 1);
    check("t3_empty_send_pkt_count", pkt_count, 1);
    check("t3_empty_send_overflow", overflow, 0);
    drain("t3");
    check("t3_sop_cnt", sop_cnt, 3);
    check("t3_eop_cnt", eop_cnt, 3);

    // Buffer overflow drops the whole packet
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send_word(mkword(3 * i), 1, 0);
    send_word('0, 0, 1);
    check("t4_overflow", overflow, 1);
    check("t4_pkt_count", pkt_count, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_output", out_valid, 0);
    w0 = mkword(200);
    expect_word(w0, 1, 1);
    exp_pkts = 1;
    send_word(w0, 1, 1);
    ready_mode = 1;
    drain("t4");
    check("t4_eop_cnt", eop_cnt, 4);

    // Reset in the middle of emission
    w0 = mkword(7);
    expect_word(w0, 1, 1);
    exp_pkts = 1;
    hs0 = hs_cnt;
    send_word(w0, 1, 1);
    n = 0;
    while (hs_cnt < hs0 + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_beat5", hs_cnt - hs0, 5);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_sop", out_sop, 0);
    check("t6_rst_eop", out_eop, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_pkt_count", pkt_count, 0);
    check("t6_rst_overflow", overflow, 0);
    sb.delete();
    exp_pkts = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    w0 = mkword(150);
    expect_word(w0, 1, 1);
    exp_pkts = 1;
    send_word(w0, 1, 1);
    drain("t6");

    // Descriptor FIFO full
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sop0 = sop_cnt;
    eop0 = eop_cnt;
    for (int i = 0; i < 4; i++) begin
      w0 = mkword(40 * i + 1);
      expect_word(w0, 1, 1);
      send_word(w0, 1, 1);
    end
    exp_pkts = 4;
    check("t5_pkt_count_4", pkt_count, 4);
    check("t5_overflow_before", overflow, 0);
    send_word(mkword(250), 1, 1);
    check("t5_pkt_count_kept", pkt_count, 4);
    check("t5_overflow_after", overflow, 1);
    ready_mode = 1;
    drain("t5");
    check("t5_sop_pairs", sop_cnt - sop0, 4);
    check("t5_eop_pairs", eop_cnt - eop0, 4);
    check("t5_pkt_count_end", pkt_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
